// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-port 32-bit memory between instruction fetch
//               and MEM-stage data ports; data-first with starvation guard.
//               Optional abort-on-timeout when ARB_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
   parameter int unsigned STARVE_MAX = 4,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ready,
   input  logic        d_rd,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic [31:0] d_rdata,
   output logic        d_ready,
   output logic        m_req,
   output logic        m_we,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   input  logic [31:0] m_rdata,
   input  logic        m_ack,
   output logic        bus_err
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_BUSY_I = 2'd1,
      S_BUSY_D = 2'd2
   } state_t;

   localparam logic [3:0] c_starve_max = 4'(STARVE_MAX);
   localparam logic [3:0] c_starve_sat = 4'hF;
   localparam bit         c_starve_en  = (STARVE_MAX > 0);

   state_t      r_state;
   logic        r_m_req;
   logic        r_m_we;
   logic [31:0] r_m_addr;
   logic [31:0] r_m_wdata;
   logic [31:0] r_if_rdata;
   logic [31:0] r_d_rdata;
   logic        r_if_ready;
   logic        r_d_ready;
   logic        r_mask_i;
   logic        r_mask_d;
   logic [3:0]  r_starve;

   logic        w_d_req;
   logic        w_busy;
   logic        w_timeout;
   logic        w_ack_i;
   logic        w_ack_d;
   logic        w_done_i;
   logic        w_done_d;
   logic        w_arb;
   logic        w_cand_i;
   logic        w_cand_d;
   logic        w_fetch_first;
   logic        w_grant_i;
   logic        w_grant_d;

   assign w_d_req  = d_rd | d_we;
   assign w_busy   = (r_state != S_IDLE);
   assign w_ack_i  = (r_state == S_BUSY_I) && m_ack;
   assign w_ack_d  = (r_state == S_BUSY_D) && m_ack;
   assign w_done_i = (r_state == S_BUSY_I) && (m_ack || w_timeout);
   assign w_done_d = (r_state == S_BUSY_D) && (m_ack || w_timeout);

   // An aborted access returns to IDLE with m_req low; only a real ack re-arbitrates in place.
   assign w_arb = (r_state == S_IDLE) || w_ack_i || w_ack_d;

   // The port being completed still holds its request, so it is excluded until its ready cycle ends.
   assign w_cand_i = if_req  && !r_mask_i && !w_done_i;
   assign w_cand_d = w_d_req && !r_mask_d && !w_done_d;

   assign w_fetch_first = c_starve_en && w_cand_i && (r_starve == c_starve_max);
   assign w_grant_i     = w_arb && w_cand_i && (!w_cand_d || w_fetch_first);
   assign w_grant_d     = w_arb && w_cand_d && !w_grant_i;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_m_req    <= 1'b0;
         r_m_we     <= 1'b0;
         r_m_addr   <= '0;
         r_m_wdata  <= '0;
         r_if_rdata <= '0;
         r_d_rdata  <= '0;
         r_if_ready <= 1'b0;
         r_d_ready  <= 1'b0;
         r_mask_i   <= 1'b0;
         r_mask_d   <= 1'b0;
         r_starve   <= '0;
      end else begin
         r_if_ready <= 1'b0;
         r_d_ready  <= 1'b0;
         r_mask_i   <= w_done_i;
         r_mask_d   <= w_done_d;

         if (!if_req || w_grant_i) begin
            r_starve <= '0;
         end else if (w_grant_d && w_cand_i && (r_starve != c_starve_sat)) begin
            r_starve <= r_starve + 4'd1;
         end

         if (w_done_i) begin
            r_if_ready <= 1'b1;
            r_if_rdata <= w_timeout ? 32'h0 : m_rdata;
         end

         // Write completions (including read+write) leave d_rdata untouched.
         if (w_done_d) begin
            r_d_ready <= 1'b1;
            if (w_timeout) begin
               r_d_rdata <= 32'h0;
            end else if (!r_m_we) begin
               r_d_rdata <= m_rdata;
            end
         end

         if (w_grant_i) begin
            r_state   <= S_BUSY_I;
            r_m_req   <= 1'b1;
            r_m_we    <= 1'b0;
            r_m_addr  <= if_addr;
            r_m_wdata <= 32'h0;
         end else if (w_grant_d) begin
            r_state   <= S_BUSY_D;
            r_m_req   <= 1'b1;
            r_m_we    <= d_we;
            r_m_addr  <= d_addr;
            r_m_wdata <= d_wdata;
         end else if (w_done_i || w_done_d) begin
            r_state   <= S_IDLE;
            r_m_req   <= 1'b0;
         end
      end
   end

`ifdef ARB_TIMEOUT_EN
   localparam logic [7:0] c_timeout_last = 8'(TIMEOUT - 1);

   logic [7:0] r_wait;
   logic       r_bus_err;

   assign w_timeout = w_busy && !m_ack && (r_wait == c_timeout_last);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wait    <= '0;
         r_bus_err <= 1'b0;
      end else begin
         r_bus_err <= w_timeout;
         if (w_grant_i || w_grant_d) begin
            r_wait <= '0;
         end else if (w_busy && !m_ack) begin
            r_wait <= r_wait + 8'd1;
         end
      end
   end

   assign bus_err = r_bus_err;
`else
   logic w_unused_timeout;

   assign w_timeout        = 1'b0;
   assign bus_err          = 1'b0;
   assign w_unused_timeout = |8'(TIMEOUT) | w_busy;
`endif

   assign m_req    = r_m_req;
   assign m_we     = r_m_we;
   assign m_addr   = r_m_addr;
   assign m_wdata  = r_m_wdata;
   assign if_rdata = r_if_rdata;
   assign if_ready = r_if_ready;
   assign d_rdata  = r_d_rdata;
   assign d_ready  = r_d_ready;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed and randomized self-checking bench for mem_port_arbiter
//               against a behavioural memory and requester model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

   localparam int STARVE_MAX = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_req, d_rd, d_we, m_ack;
   logic [31:0] if_addr, d_addr, d_wdata, m_rdata;
   logic [31:0] if_rdata, d_rdata, m_addr, m_wdata;
   logic        if_ready, d_ready, m_req, m_we, bus_err;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          resp_wait;
   bit          resp_rand;
   logic [31:0] exp_d_rdata;
   logic [31:0] mem    [logic [31:0]];
   logic [31:0] shadow [logic [31:0]];
   bit          grant_q[$];

   mem_port_arbiter #(.STARVE_MAX(STARVE_MAX), .TIMEOUT(255)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
      .d_rd(d_rd), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ready(d_ready),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_rdata(m_rdata), .m_ack(m_ack), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] dflt(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
   endfunction

   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   // Memory: acks after a configurable number of wait cycles, checks request stability.
   initial begin : memory_model
      logic [31:0] s_addr, s_wdata;
      logic        s_we;
      bit          in_txn;
      int          wait_left;
      in_txn = 1'b0; wait_left = 0; s_addr = '0; s_wdata = '0; s_we = 1'b0;
      m_ack = 1'b0; m_rdata = '0;
      forever begin
         @(negedge clk);
         m_ack = 1'b0;
         if (!m_req) begin
            in_txn = 1'b0;
         end else begin
            if (!in_txn) begin
               in_txn = 1'b1; s_addr = m_addr; s_we = m_we; s_wdata = m_wdata;
               wait_left = resp_rand ? int'($urandom_range(0, 3)) : resp_wait;
               grant_q.push_back(!m_addr[16]);
            end else begin
               n_tests++;
               if ({m_addr, m_we, m_wdata} !== {s_addr, s_we, s_wdata}) begin
                  n_fail++;
                  $display("FAIL m_stable: got %h/%b/%h want %h/%b/%h", m_addr, m_we, m_wdata, s_addr, s_we, s_wdata);
               end
            end
            if (wait_left == 0) begin
               m_ack = 1'b1; in_txn = 1'b0;
               if (s_we) begin
                  mem[s_addr] = s_wdata; m_rdata = 32'hDEAD_BEEF;
               end else begin
                  m_rdata = mem.exists(s_addr) ? mem[s_addr] : dflt(s_addr);
               end
            end else begin
               wait_left--;
            end
         end
      end
   end

   task automatic test_reset;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_tests++; if (m_req !== 1'b0)     begin n_fail++; $display("FAIL rst_m_req: got %b want 0", m_req); end
      n_tests++; if (m_we !== 1'b0)      begin n_fail++; $display("FAIL rst_m_we: got %b want 0", m_we); end
      n_tests++; if (if_ready !== 1'b0)  begin n_fail++; $display("FAIL rst_if_ready: got %b want 0", if_ready); end
      n_tests++; if (d_ready !== 1'b0)   begin n_fail++; $display("FAIL rst_d_ready: got %b want 0", d_ready); end
      n_tests++; if (bus_err !== 1'b0)   begin n_fail++; $display("FAIL rst_bus_err: got %b want 0", bus_err); end
      n_tests++; if (m_addr !== 32'h0)   begin n_fail++; $display("FAIL rst_m_addr: got %h want 0", m_addr); end
      n_tests++; if (m_wdata !== 32'h0)  begin n_fail++; $display("FAIL rst_m_wdata: got %h want 0", m_wdata); end
      n_tests++; if (if_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_if_rdata: got %h want 0", if_rdata); end
      n_tests++; if (d_rdata !== 32'h0)  begin n_fail++; $display("FAIL rst_d_rdata: got %h want 0", d_rdata); end
      next_cycle;
      rst = 1'b0;
      next_cycle;
   endtask

   task automatic test_fetch_latency;
      resp_wait = 0; if_req = 1'b1; if_addr = 32'h0000_0040;
      @(negedge clk);
      n_tests++; if (m_req !== 1'b0) begin n_fail++; $display("FAIL fetch_c0_m_req: got %b want 0", m_req); end
      next_cycle; @(negedge clk);
      n_tests++; if (m_req !== 1'b1)        begin n_fail++; $display("FAIL fetch_c1_m_req: got %b want 1", m_req); end
      n_tests++; if (m_addr !== 32'h40)     begin n_fail++; $display("FAIL fetch_c1_m_addr: got %h want 40", m_addr); end
      n_tests++; if (m_we !== 1'b0)         begin n_fail++; $display("FAIL fetch_c1_m_we: got %b want 0", m_we); end
      n_tests++; if (if_ready !== 1'b0)     begin n_fail++; $display("FAIL fetch_c1_if_ready: got %b want 0", if_ready); end
      next_cycle; @(negedge clk);
      n_tests++; if (if_ready !== 1'b1)          begin n_fail++; $display("FAIL fetch_c2_if_ready: got %b want 1", if_ready); end
      n_tests++; if (if_rdata !== 32'h2008_0005) begin n_fail++; $display("FAIL fetch_c2_if_rdata: got %h want 20080005", if_rdata); end
      n_tests++; if (m_req !== 1'b0)             begin n_fail++; $display("FAIL fetch_c2_m_req: got %b want 0", m_req); end
      next_cycle; if_req = 1'b0; @(negedge clk);
      n_tests++; if (if_ready !== 1'b0) begin n_fail++; $display("FAIL fetch_c3_if_ready: got %b want 0", if_ready); end
      repeat (2) next_cycle;
   endtask

   task automatic test_data_priority;
      resp_wait = 0;
      if_req = 1'b1; if_addr = 32'h0000_0080; d_rd = 1'b1; d_addr = 32'h0000_0100;
      @(negedge clk);
      n_tests++; if (m_req !== 1'b0) begin n_fail++; $display("FAIL prio_c0_m_req: got %b want 0", m_req); end
      next_cycle; @(negedge clk);
      n_tests++; if (m_req !== 1'b1)     begin n_fail++; $display("FAIL prio_c1_m_req: got %b want 1", m_req); end
      n_tests++; if (m_addr !== 32'h100) begin n_fail++; $display("FAIL prio_c1_m_addr: got %h want 100", m_addr); end
      next_cycle; @(negedge clk);
      n_tests++; if (m_req !== 1'b1)             begin n_fail++; $display("FAIL prio_c2_m_req: got %b want 1", m_req); end
      n_tests++; if (m_addr !== 32'h80)          begin n_fail++; $display("FAIL prio_c2_m_addr: got %h want 80", m_addr); end
      n_tests++; if (d_ready !== 1'b1)           begin n_fail++; $display("FAIL prio_c2_d_ready: got %b want 1", d_ready); end
      n_tests++; if (d_rdata !== dflt(32'h100))  begin n_fail++; $display("FAIL prio_c2_d_rdata: got %h want %h", d_rdata, dflt(32'h100)); end
      exp_d_rdata = dflt(32'h100);
      next_cycle; d_rd = 1'b0; @(negedge clk);
      n_tests++; if (if_ready !== 1'b1)         begin n_fail++; $display("FAIL prio_c3_if_ready: got %b want 1", if_ready); end
      n_tests++; if (if_rdata !== dflt(32'h80)) begin n_fail++; $display("FAIL prio_c3_if_rdata: got %h want %h", if_rdata, dflt(32'h80)); end
      n_tests++; if (d_ready !== 1'b0)          begin n_fail++; $display("FAIL prio_c3_d_ready: got %b want 0", d_ready); end
      n_tests++; if (m_req !== 1'b0)            begin n_fail++; $display("FAIL prio_c3_m_req: got %b want 0", m_req); end
      next_cycle; if_req = 1'b0;
      repeat (2) next_cycle;
   endtask

   task automatic test_write_wait;
      int nready;
      nready = 0; resp_wait = 3;
      d_we = 1'b1; d_addr = 32'h0000_0200; d_wdata = 32'hCAFE_F00D;
      for (int c = 1; c <= 8; c++) begin
         next_cycle;
         if (c == 6) d_we = 1'b0;
         @(negedge clk);
         if (d_ready) nready++;
         if (c <= 4) begin
            n_tests++;
            if ({m_req, m_we, m_addr, m_wdata} !== {1'b1, 1'b1, 32'h200, 32'hCAFE_F00D}) begin
               n_fail++;
               $display("FAIL wr_hold_c%0d: got %b/%b/%h/%h want 1/1/200/cafef00d", c, m_req, m_we, m_addr, m_wdata);
            end
         end
         if (c == 5) begin
            n_tests++; if (d_ready !== 1'b1)      begin n_fail++; $display("FAIL wr_c5_d_ready: got %b want 1", d_ready); end
            n_tests++; if (d_rdata !== exp_d_rdata) begin n_fail++; $display("FAIL wr_c5_d_rdata: got %h want %h", d_rdata, exp_d_rdata); end
            n_tests++; if (m_req !== 1'b0)        begin n_fail++; $display("FAIL wr_c5_m_req: got %b want 0", m_req); end
         end
      end
      n_tests++; if (nready != 1) begin n_fail++; $display("FAIL wr_ready_count: got %0d want 1", nready); end
      n_tests++;
      if (!mem.exists(32'h200) || mem[32'h200] !== 32'hCAFE_F00D) begin
         n_fail++; $display("FAIL wr_mem_content: got %h want cafef00d", mem.exists(32'h200) ? mem[32'h200] : 32'h0);
      end
      next_cycle;
   endtask

   task automatic test_starvation;
      int run, maxrun, nf, sz;
      run = 0; maxrun = 0; nf = 0;
      resp_wait = 0; resp_rand = 1'b0;
      grant_q.delete();
      if_req = 1'b1; if_addr = 32'h0000_0300; d_rd = 1'b1; d_addr = 32'h0001_0400;
      repeat (80) next_cycle;
      sz = grant_q.size();
      n_tests++;
      if (sz == 0 || grant_q[0] !== 1'b0) begin n_fail++; $display("FAIL starve_first_grant: got size %0d want data first", sz); end
      for (int k = 0; k < sz; k++) begin
         if (grant_q[k]) begin nf++; run = 0; end
         else begin run++; if (run > maxrun) maxrun = run; end
      end
      n_tests++; if (maxrun > STARVE_MAX) begin n_fail++; $display("FAIL starve_max_run: got %0d want <= %0d", maxrun, STARVE_MAX); end
      n_tests++; if (nf < 5) begin n_fail++; $display("FAIL starve_fetch_grants: got %0d want >= 5", nf); end
      if_req = 1'b0; d_rd = 1'b0;
      exp_d_rdata = dflt(32'h0001_0400);
      repeat (8) next_cycle;
   endtask

   task automatic test_reset_mid;
      int dr;
      bit got;
      dr = 0; got = 1'b0;
      resp_wait = 20; d_rd = 1'b1; d_addr = 32'h0001_0500;
      next_cycle;
      next_cycle; if_req = 1'b1; if_addr = 32'h0000_0600;
      @(negedge clk);
      n_tests++; if (m_req !== 1'b1 || m_addr !== 32'h0001_0500) begin n_fail++; $display("FAIL rmid_busy: got %b/%h want 1/00010500", m_req, m_addr); end
      @(posedge clk); #3; rst = 1'b1; #1;
      n_tests++; if (m_req !== 1'b0)   begin n_fail++; $display("FAIL rmid_m_req_async: got %b want 0", m_req); end
      n_tests++; if (d_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_d_ready: got %b want 0", d_ready); end
      next_cycle; d_rd = 1'b0; resp_wait = 0;
      next_cycle; rst = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (d_ready) dr++;
         if (if_ready) begin got = 1'b1; break; end
         next_cycle;
      end
      n_tests++; if (!got) begin n_fail++; $display("FAIL rmid_fetch_timeout: got no if_ready want pulse"); end
      n_tests++; if (if_rdata !== dflt(32'h600)) begin n_fail++; $display("FAIL rmid_if_rdata: got %h want %h", if_rdata, dflt(32'h600)); end
      n_tests++; if (dr != 0) begin n_fail++; $display("FAIL rmid_spurious_d_ready: got %0d want 0", dr); end
      exp_d_rdata = 32'h0;
      next_cycle; if_req = 1'b0;
      repeat (2) next_cycle;
   endtask

   task automatic fetch_agent(input int n);
      logic [31:0] a;
      int          dcnt;
      bit          got;
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, 3)) next_cycle;
         a = 32'h0000_1000 + ($urandom_range(0, 255) << 2);
         if_addr = a; if_req = 1'b1; dcnt = 0; got = 1'b0;
         for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (if_ready) begin got = 1'b1; break; end
            if (d_ready) dcnt++;
            next_cycle;
         end
         n_tests++;
         if (!got) begin
            n_fail++; $display("FAIL rnd_fetch_timeout: got no if_ready want pulse for %h", a);
         end else begin
            n_tests++; if (if_rdata !== dflt(a)) begin n_fail++; $display("FAIL rnd_if_rdata: got %h want %h", if_rdata, dflt(a)); end
            n_tests++; if (dcnt > STARVE_MAX + 1) begin n_fail++; $display("FAIL rnd_fetch_starved: got %0d want <= %0d", dcnt, STARVE_MAX + 1); end
         end
         next_cycle; if_req = 1'b0;
      end
   endtask

   task automatic data_agent(input int n);
      logic [31:0] a, wd, exp;
      int          op;
      bit          got;
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, 3)) next_cycle;
         op = int'($urandom_range(0, 2));
         a  = 32'h0001_0000 + ($urandom_range(0, 15) << 2);
         wd = $urandom;
         d_addr = a; d_wdata = wd; d_rd = (op != 1); d_we = (op != 0); got = 1'b0;
         for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (d_ready) begin got = 1'b1; break; end
            next_cycle;
         end
         n_tests++;
         if (!got) begin
            n_fail++; $display("FAIL rnd_data_timeout: got no d_ready want pulse for %h", a);
         end else if (op != 0) begin
            shadow[a] = wd;
            n_tests++; if (d_rdata !== exp_d_rdata) begin n_fail++; $display("FAIL rnd_wr_d_rdata: got %h want %h", d_rdata, exp_d_rdata); end
         end else begin
            exp = shadow.exists(a) ? shadow[a] : dflt(a);
            n_tests++; if (d_rdata !== exp) begin n_fail++; $display("FAIL rnd_rd_d_rdata: got %h want %h", d_rdata, exp); end
            exp_d_rdata = exp;
         end
         next_cycle; d_rd = 1'b0; d_we = 1'b0;
      end
   endtask

   task automatic test_random;
      resp_rand = 1'b1;
      fork
         fetch_agent(40);
         data_agent(40);
      join
      @(negedge clk);
      n_tests++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL rnd_bus_err: got %b want 0", bus_err); end
      resp_rand = 1'b0;
      next_cycle;
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: got time limit want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      if_req = 1'b0; if_addr = '0; d_rd = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
      resp_wait = 0; resp_rand = 1'b0; exp_d_rdata = 32'h0;
      mem[32'h0000_0040] = 32'h2008_0005;
      test_reset;
      test_fetch_latency;
      test_data_priority;
      test_write_wait;
      test_starvation;
      test_reset_mid;
      test_random;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
